// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, common keyboard commands
// and the odd-parity frame builder used by the send path.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INHIBIT,
      RQST,
      DATA,
      STOP,
      ACK,
      WAITIDLE,
      DONE,
      ERR
   } ps2_tx_state_e;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

   // Parity bit sits above the byte so the frame shifts out LSB first.
   function automatic logic [8:0] ps2_frame(input logic [7:0] data);
      return {~^data, data};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
// Idle level of both PS/2 lines is high, so the flops reset to 1.
module ps2_sync_edge (
   input  logic i_clock,
   input  logic i_resetn,
   input  logic i_line,
   output logic o_sync,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one byte plus odd parity out on device clock falls and checks the ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 1200,
   parameter int TIMEOUT_CYCLES = 150000
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   input  logic       i_ps2_clk_in,
   input  logic       i_ps2_data_in,
   output logic       o_ps2_clk_oe,
   output logic       o_ps2_data_oe,
   output logic       o_busy,
   output logic       o_tx_done,
   output logic       o_tx_error
);

   localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0]  TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

   ps2_tx_state_e r_state;
   ps2_tx_state_e w_next;

   logic [8:0]    r_frame;
   logic [3:0]    r_bit_cnt;
   logic [TW-1:0] r_timer;
   logic          r_clk_oe;
   logic          r_data_oe;

   logic w_clk_sync;
   logic w_clk_fall;
   logic w_data_sync;
   logic w_unused_data_fall;
   logic w_timed;
   logic w_restart;

   ps2_sync_edge u_clk_sync (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_line   (i_ps2_clk_in),
      .o_sync   (w_clk_sync),
      .o_fall   (w_clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_line   (i_ps2_data_in),
      .o_sync   (w_data_sync),
      .o_fall   (w_unused_data_fall)
   );

   assign w_timed   = r_state inside {RQST, DATA, STOP, ACK, WAITIDLE};
   assign w_restart = w_clk_fall && (r_state inside {DATA, STOP, ACK});

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) r_state <= IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (i_tx_valid) w_next = INHIBIT;
         INHIBIT:  if (r_timer == INHIBIT_LAST) w_next = RQST;
         RQST:     w_next = DATA;
         DATA:     if (w_clk_fall && r_bit_cnt == 4'd8) w_next = STOP;
         STOP:     if (w_clk_fall) w_next = ACK;
         ACK:      if (w_clk_fall) w_next = w_data_sync ? ERR : WAITIDLE;
         WAITIDLE: if (w_clk_sync && w_data_sync) w_next = DONE;
         DONE:     w_next = IDLE;
         ERR:      w_next = IDLE;
         default:  w_next = IDLE;
      endcase
      // A silent device must never strand the bus, whatever phase we are in.
      if (w_timed && r_timer >= TIMEOUT_MAX) w_next = ERR;
   end

   always_comb begin
      o_tx_ready = (r_state == IDLE);
      o_busy     = (r_state != IDLE);
      o_tx_done  = (r_state == DONE);
      o_tx_error = (r_state == ERR);
   end

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_frame   <= '0;
         r_bit_cnt <= '0;
         r_timer   <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
      end else begin
         if (r_state != w_next || w_restart) r_timer <= '0;
         else if (r_timer != TIMEOUT_MAX)    r_timer <= r_timer + TW'(1);

         case (r_state)
            IDLE: if (i_tx_valid) begin
               r_frame   <= ps2_frame(i_tx_data);
               r_bit_cnt <= 4'd0;
               r_clk_oe  <= 1'b1;
            end
            INHIBIT: if (w_next == RQST) r_data_oe <= 1'b1;
            RQST:    r_clk_oe <= 1'b0;
            DATA: if (w_clk_fall) begin
               r_data_oe <= ~r_frame[r_bit_cnt];
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            STOP:    if (w_clk_fall) r_data_oe <= 1'b0;
            default: ;
         endcase

         // Release both lines as soon as an error is decided.
         if (w_next == ERR) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
         end
      end
   end

   assign o_ps2_clk_oe  = r_clk_oe;
   assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Drives ps2_host_tx against a behavioural open-drain keyboard that clocks the
// frame, samples data on rising edges and answers with ACK, NAK or silence.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 120;
   localparam int TMO = 3000;

   logic       clock;
   logic       resetn;
   logic [7:0] txData;
   logic       txValid;
   logic       txReady;
   logic       ps2ClkOe;
   logic       ps2DataOe;
   logic       busy;
   logic       txDone;
   logic       txError;

   logic devClkLow;
   logic devDataLow;
   logic ps2Clk;
   logic ps2Data;

   int vectorCount = 0;
   int missCount   = 0;
   int doneCount   = 0;
   int errorCount  = 0;
   int devFallCount = 0;

   assign ps2Clk  = ~(ps2ClkOe | devClkLow);
   assign ps2Data = ~(ps2DataOe | devDataLow);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clock       (clock),
      .i_resetn      (resetn),
      .i_tx_data     (txData),
      .i_tx_valid    (txValid),
      .o_tx_ready    (txReady),
      .i_ps2_clk_in  (ps2Clk),
      .i_ps2_data_in (ps2Data),
      .o_ps2_clk_oe  (ps2ClkOe),
      .o_ps2_data_oe (ps2DataOe),
      .o_busy        (busy),
      .o_tx_done     (txDone),
      .o_tx_error    (txError)
   );

   initial clock = 1'b0;
   always #50 clock = ~clock;

   // Pulses are tallied on the falling edge, well away from DUT updates.
   always @(negedge clock) begin
      if (txDone)  doneCount++;
      if (txError) errorCount++;
   end

   initial begin
      #(6_000_000 * 100);
      $display("[TB] FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic applyStimulus(input logic [7:0] data);
      @(negedge clock);
      txData  = data;
      txValid = 1'b1;
      @(negedge clock);
      txValid = 1'b0;
   endtask

   // Reference frame as the keyboard should see it: start, 8 data LSB first,
   // odd parity, stop.
   function automatic logic [10:0] expectedFrame(input logic [7:0] data);
      int ones;
      logic [10:0] f;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         ones += int'(data[i]);
         f[i+1] = data[i];
      end
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic keyboardFrame(input int halfCycles, input bit nak, input bit silent,
                                output logic [10:0] seen, output int lowCycles,
                                output bit timedOut);
      int n;
      seen = '0;
      lowCycles = 0;
      timedOut = 1'b0;
      n = 0;
      while (ps2Clk && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (ps2Clk) begin
         timedOut = 1'b1;
         return;
      end
      while (!ps2Clk && lowCycles < INH + 100) begin
         @(negedge clock);
         lowCycles++;
      end
      if (!ps2Clk) begin
         timedOut = 1'b1;
         return;
      end
      seen[0] = ps2Data;
      if (silent) return;
      waitCycles(halfCycles);
      for (int i = 0; i < 10; i++) begin
         devClkLow = 1'b1;
         devFallCount++;
         waitCycles(halfCycles);
         devClkLow = 1'b0;
         seen[i+1] = ps2Data;
         waitCycles(halfCycles / 2);
         if (i == 9 && !nak) devDataLow = 1'b1;
         waitCycles(halfCycles - halfCycles / 2);
      end
      devClkLow = 1'b1;
      devFallCount++;
      waitCycles(halfCycles);
      devClkLow = 1'b0;
      waitCycles(halfCycles / 2);
      devDataLow = 1'b0;
   endtask

   task automatic waitOutcome(input int doneBefore, input int errBefore,
                              output int dDone, output int dErr);
      int n;
      n = 0;
      while (doneCount == doneBefore && errorCount == errBefore && n < 300) begin
         @(negedge clock);
         n++;
      end
      waitCycles(5);
      dDone = doneCount - doneBefore;
      dErr  = errorCount - errBefore;
   endtask

   task automatic runTransfer(input logic [7:0] data, input bit nak,
                              input bit injectLate, input string tag);
      logic [10:0] seen;
      int lowC, dD, dE, half, doneB, errB;
      bit tOut;
      half  = 30 + int'($urandom_range(0, 20));
      doneB = doneCount;
      errB  = errorCount;
      checkOutput({tag, ".readyBefore"}, txReady, 1);
      fork
         applyStimulus(data);
         keyboardFrame(half, nak, 1'b0, seen, lowC, tOut);
         if (injectLate) begin
            waitCycles(400);
            checkOutput({tag, ".busyAtLate"}, busy, 1);
            txData  = 8'h55;
            txValid = 1'b1;
            @(negedge clock);
            txValid = 1'b0;
         end
      join
      checkOutput({tag, ".bound"}, tOut, 0);
      checkOutput({tag, ".inhibit"}, (lowC >= INH && lowC <= INH + 3), 1);
      checkOutput({tag, ".frame"}, seen, expectedFrame(data));
      waitOutcome(doneB, errB, dD, dE);
      checkOutput({tag, ".done"}, dD, nak ? 0 : 1);
      checkOutput({tag, ".error"}, dE, nak ? 1 : 0);
      checkOutput({tag, ".readyAfter"}, txReady, 1);
   endtask

   initial begin
      logic [10:0] seen;
      int lowC, n, doneB, errB;
      bit tOut;

      resetn     = 1'b0;
      txData     = '0;
      txValid    = 1'b0;
      devClkLow  = 1'b0;
      devDataLow = 1'b0;
      waitCycles(3);
      checkOutput("reset.ready", txReady, 1);
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.oes", {ps2ClkOe, ps2DataOe}, 0);
      checkOutput("reset.pulses", {txDone, txError}, 0);
      resetn = 1'b1;
      waitCycles(5);

      $display("[TB] set-LEDs command with ACK");
      runTransfer(PS2_CMD_SET_LEDS, 1'b0, 1'b0, "ed");

      $display("[TB] parity corner bytes and random bytes");
      runTransfer(8'h01, 1'b0, 1'b0, "x01");
      runTransfer(8'h00, 1'b0, 1'b0, "x00");
      runTransfer(PS2_CMD_RESET, 1'b0, 1'b0, "xff");
      for (int k = 0; k < 4; k++) runTransfer(8'($urandom), 1'b0, 1'b0, "rand");

      $display("[TB] silent device timeout");
      doneB = doneCount;
      errB  = errorCount;
      fork
         applyStimulus(8'hF4);
         keyboardFrame(40, 1'b0, 1'b1, seen, lowC, tOut);
      join
      checkOutput("tmo.bound", tOut, 0);
      checkOutput("tmo.startBit", seen[0], 0);
      n = 0;
      while (!txError && n < TMO + 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("tmo.window", (n >= TMO - 3 && n <= TMO + 3), 1);
      checkOutput("tmo.oes", {ps2ClkOe, ps2DataOe}, 0);
      checkOutput("tmo.noDone", txDone, 0);
      @(negedge clock);
      checkOutput("tmo.ready", txReady, 1);
      waitCycles(5);
      checkOutput("tmo.errCount", errorCount - errB, 1);
      checkOutput("tmo.doneCount", doneCount - doneB, 0);

      $display("[TB] NAK on the acknowledge clock");
      runTransfer(8'hA5, 1'b1, 1'b0, "nak");

      $display("[TB] second request during a transfer is ignored");
      runTransfer(PS2_CMD_SET_LEDS, 1'b0, 1'b1, "overlap");

      $display("[TB] reset in the middle of data bit 4");
      doneB = doneCount;
      errB  = errorCount;
      devFallCount = 0;
      fork
         applyStimulus(PS2_CMD_SET_LEDS);
         keyboardFrame(40, 1'b0, 1'b0, seen, lowC, tOut);
         begin
            n = 0;
            while (devFallCount < 5 && n < 5000) begin
               @(negedge clock);
               n++;
            end
            checkOutput("rst.reachBit4", devFallCount >= 5, 1);
            waitCycles(5);
            checkOutput("rst.busyBefore", busy, 1);
            checkOutput("rst.dataDriven", ps2DataOe, 1);
            #20 resetn = 1'b0;
            #1;
            checkOutput("rst.oes", {ps2ClkOe, ps2DataOe}, 0);
            checkOutput("rst.ready", txReady, 1);
            checkOutput("rst.busy", busy, 0);
            waitCycles(3);
            resetn = 1'b1;
         end
      join
      waitCycles(200);
      checkOutput("rst.noDone", doneCount - doneB, 0);
      checkOutput("rst.noError", errorCount - errB, 0);

      runTransfer(PS2_CMD_RESET, 1'b0, 1'b0, "afterRst");

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
